// File: rtl/mips150_store_unit.sv
// mips150_store_unit
//   Store-side lane/enable generator plus a small in-order store buffer.
//   SB/SH/SW requests from execute are converted into word-aligned,
//   big-endian, byte-enabled writes. Each write is queued in a FIFO and then
//   drained to the data memory over a valid/ready handshake.
//   Misaligned stores and reserved sizes are consumed but never written.
//   Buffered stores that hit the load word raise a hazard flag.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   st_valid/st_ready           request handshake from execute
//   st_size/st_addr/st_data     request (size 00=B 01=H 10=W 11=reserved)
//   mem_valid/mem_ready         drain handshake to data memory
//   mem_addr/mem_wdata/mem_we   head entry (word address, lanes, enables)
//   ld_addr/ld_hazard           load-word vs buffered-store match
//   misalign_err/err_addr       one-cycle error pulse, last bad address
//   pending                     number of occupied entries
module mips150_store_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [1:0]               st_size,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_we,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  output logic                     misalign_err,
  output logic [AW-1:0]            err_addr,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Buffer storage; a word address drops the two byte-offset bits.
  logic [AW-3:0]  ent_addr_q  [DEPTH];
  logic [31:0]    ent_wdata_q [DEPTH];
  logic [3:0]     ent_we_q    [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           misalign_q, misalign_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;

  logic           req_legal;
  logic [3:0]     req_we;
  logic [31:0]    req_wdata;
  logic           accept;
  logic           enq;
  logic           deq;
  logic           hazard;
  logic [PW-1:0]  scan_idx;

  // Decode request size/offset into byte enables and replicated lane data.
  always_comb begin
    req_legal = 1'b0;
    req_we    = 4'b0000;
    req_wdata = 32'h0000_0000;
    case (st_size)
      2'b00: begin
        req_legal = 1'b1;
        req_we    = 4'b1000 >> st_addr[1:0];
        req_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        req_legal = (st_addr[0] == 1'b0);
        req_we    = st_addr[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{st_data[15:0]}};
      end
      2'b10: begin
        req_legal = (st_addr[1:0] == 2'b00);
        req_we    = 4'b1111;
        req_wdata = st_data;
      end
      default: begin
        req_legal = 1'b0;
        req_we    = 4'b0000;
        req_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Handshakes, pointer/occupancy next state and error capture.
  always_comb begin
    st_ready   = (count_q < CW'(DEPTH));
    mem_valid  = (count_q != {CW{1'b0}});
    accept     = st_valid && st_ready;
    enq        = accept && req_legal;
    deq        = mem_valid && mem_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = accept && !req_legal;
    err_addr_d = err_addr_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept && !req_legal) begin
      err_addr_d = st_addr;
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  // Hazard scan: only occupied entries (rd_ptr onward, count of them) match;
  // the request being accepted right now is not yet in storage.
  always_comb begin
    hazard   = 1'b0;
    scan_idx = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr_q[scan_idx] == ld_addr[AW-1:2])) begin
        hazard = 1'b1;
      end else begin
        hazard = hazard;
      end
    end
  end

  // Output drive: head entry while valid, zeros while empty.
  always_comb begin
    ld_hazard    = hazard;
    misalign_err = misalign_q;
    err_addr     = err_addr_q;
    pending      = count_q;
    if (mem_valid) begin
      mem_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
      mem_wdata = ent_wdata_q[rd_ptr_q];
      mem_we    = ent_we_q[rd_ptr_q];
    end else begin
      mem_addr  = {AW{1'b0}};
      mem_wdata = 32'h0000_0000;
      mem_we    = 4'b0000;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      misalign_q <= 1'b0;
      err_addr_q <= {AW{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Entry storage; written only on a legal enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= {(AW-2){1'b0}};
        ent_wdata_q[i] <= 32'h0000_0000;
        ent_we_q[i]    <= 4'b0000;
      end
    end else if (enq) begin
      ent_addr_q[wr_ptr_q]  <= st_addr[AW-1:2];
      ent_wdata_q[wr_ptr_q] <= req_wdata;
      ent_we_q[wr_ptr_q]    <= req_we;
    end
  end

endmodule

// File: tb/tb_mips150_store_unit.sv
module tb_mips150_store_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic [1:0]  pending;

  int n_cmp;
  int n_bad;

  mips150_store_unit #(.DEPTH(2), .AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_size      (st_size),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .ld_addr      (ld_addr),
    .ld_hazard    (ld_hazard),
    .misalign_err (misalign_err),
    .err_addr     (err_addr),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_size   = 2'b00;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ready = 1'b0;
    ld_addr   = 32'h0;

    // Reset state
    #2;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SB sweep with memory always ready
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req(2'b00, 32'h100 + 32'(k), 32'h0000_00A5);
      #1;
      chk("sb_no_bypass", 32'(mem_valid), 32'd0);
      @(negedge clk);
      st_valid = 1'b0;
      #1;
      chk("sb_valid", 32'(mem_valid), 32'd1);
      chk("sb_addr", mem_addr, 32'h100);
      chk("sb_we", 32'(mem_we), 32'(4'b1000 >> k));
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("sb_drained", 32'(pending), 32'd0);
    end

    // SH legal, held by backpressure
    mem_ready = 1'b0;
    req(2'b01, 32'h202, 32'h0000_1234);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_we", 32'(mem_we), 32'b0011);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_pending", 32'(pending), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sh_retired", 32'(pending), 32'd0);

    // SW legal
    req(2'b10, 32'h204, 32'hDEAD_BEEF);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("sw_addr", mem_addr, 32'h204);
    chk("sw_we", 32'(mem_we), 32'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_retired", 32'(mem_valid), 32'd0);

    // Misaligned word
    req(2'b10, 32'h301, 32'h5555_5555);
    #1;
    chk("mis_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("mis_err_pulse", 32'(misalign_err), 32'd1);
    chk("mis_err_addr", err_addr, 32'h301);
    chk("mis_no_write", 32'(mem_valid), 32'd0);
    chk("mis_pending", 32'(pending), 32'd0);
    @(negedge clk);
    chk("mis_err_end", 32'(misalign_err), 32'd0);
    chk("mis_err_hold", err_addr, 32'h301);

    // Reserved size
    req(2'b11, 32'h400, 32'h6666_6666);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("rsv_err_pulse", 32'(misalign_err), 32'd1);
    chk("rsv_err_addr", err_addr, 32'h400);
    chk("rsv_no_write", 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk("rsv_err_end", 32'(misalign_err), 32'd0);
    chk("rsv_no_write2", 32'(mem_valid), 32'd0);

    // Backpressure: three SW with memory stalled
    mem_ready = 1'b0;
    req(2'b10, 32'h600, 32'h1111_1111);
    @(negedge clk);
    chk("bp_pend1", 32'(pending), 32'd1);
    chk("bp_ready1", 32'(st_ready), 32'd1);
    req(2'b10, 32'h604, 32'h2222_2222);
    @(negedge clk);
    chk("bp_pend2", 32'(pending), 32'd2);
    chk("bp_ready2", 32'(st_ready), 32'd0);
    req(2'b10, 32'h608, 32'h3333_3333);
    @(negedge clk);
    chk("bp_full_hold", 32'(pending), 32'd2);
    chk("bp_head_addr", mem_addr, 32'h600);
    chk("bp_head_data", mem_wdata, 32'h1111_1111);
    mem_ready = 1'b1;
    #1;
    chk("bp_no_comb_ready", 32'(st_ready), 32'd0);
    @(negedge clk);
    chk("bp_after_ret1", 32'(pending), 32'd1);
    chk("bp_head2_addr", mem_addr, 32'h604);
    chk("bp_head2_data", mem_wdata, 32'h2222_2222);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("bp_third_in", 32'(pending), 32'd1);
    chk("bp_head3_addr", mem_addr, 32'h608);
    chk("bp_head3_data", mem_wdata, 32'h3333_3333);
    @(negedge clk);
    chk("bp_drained", 32'(pending), 32'd0);

    // Load/store hazard
    mem_ready = 1'b0;
    ld_addr   = 32'h50B;
    req(2'b00, 32'h508, 32'h0000_005A);
    #1;
    chk("hz_accepting_no_hit", 32'(ld_hazard), 32'd0);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'd1);
    chk("hz_we", 32'(mem_we), 32'b1000);
    ld_addr = 32'h50C;
    #1;
    chk("hz_other_word", 32'(ld_hazard), 32'd0);
    ld_addr   = 32'h50B;
    mem_ready = 1'b1;
    #1;
    chk("hz_retiring_hit", 32'(ld_hazard), 32'd1);
    @(negedge clk);
    chk("hz_after_retire", 32'(ld_hazard), 32'd0);
    chk("hz_pending", 32'(pending), 32'd0);

    // Async reset with two buffered stores
    mem_ready = 1'b0;
    req(2'b10, 32'h700, 32'h7777_0000);
    @(negedge clk);
    req(2'b10, 32'h704, 32'h7777_0004);
    @(negedge clk);
    st_valid = 1'b0;
    chk("ar_pend_before", 32'(pending), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_valid", 32'(mem_valid), 32'd0);
    chk("ar_pending", 32'(pending), 32'd0);
    chk("ar_misalign", 32'(misalign_err), 32'd0);
    chk("ar_we", 32'(mem_we), 32'd0);
    chk("ar_st_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ar_no_stale", 32'(mem_valid), 32'd0);
    end

    // Async reset during an error pulse
    req(2'b01, 32'h801, 32'h0000_8888);
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("ar2_err_set", 32'(misalign_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar2_err_clr", 32'(misalign_err), 32'd0);
    chk("ar2_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
